frame_assembler: RTL
====================

FRAME_ASSEMBLER -- requirements
Module: frame_assembler

Interface
REQ-001 SHALL have parameter in_channels, default 1, number of feature-map channels per frame.
REQ-002 SHALL have parameter rows, default 27, frame height in pixels.
REQ-003 SHALL have parameter cols, default 27, frame width in pixels.
REQ-004 SHALL have parameter data_size, default 8, bits per signed pixel.
REQ-005 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port in_data, input, data_size, signed pixel sample.
REQ-008 SHALL have port in_valid, input, 1, in_data is valid this cycle.
REQ-009 SHALL have port in_last, input, 1, marks the final pixel of a frame.
REQ-010 SHALL have port in_ready, output, 1, block can accept a pixel this cycle.
REQ-011 SHALL have port frame, output, in_channels*rows*cols*data_size, packed frame bus feeding the pooling stage.
REQ-012 SHALL have port frame_valid, output, 1, frame holds a complete frame.
REQ-013 SHALL have port frame_ready, input, 1, consumer takes the frame this cycle.
REQ-014 SHALL have port frame_err, output, 1, one-cycle pulse on framing error.

Function
REQ-015 SHALL accept a pixel only on a cycle where in_valid and in_ready are both 1.
REQ-016 SHALL take input order channel-major, then row, then column (column fastest).
REQ-017 SHALL write the pixel at (c,r,x) to frame bits [((c*rows*cols)+(r*cols)+x)*data_size +: data_size], using the full data_size width.
REQ-018 SHALL keep column, row and channel counters: column wraps cols-1 to 0 and increments row; row wraps rows-1 to 0 and increments channel.
REQ-019 SHALL use FSM states FILL and FULL; reset state is FILL.
REQ-020 SHALL hold in_ready=1 in FILL and in_ready=0 in FULL.
REQ-021 SHALL move from FILL to FULL on acceptance of pixel index N-1 (N=in_channels*rows*cols) when in_last=1, with frame_valid=1 on the next cycle (latency 1 clock from last accept).
REQ-022 SHALL, in FULL, hold frame and frame_valid=1 stable until frame_ready=1, then return to FILL with counters zero and frame_valid=0 on the next cycle.
REQ-023 SHALL treat in_last=1 on a pixel other than index N-1 as early termination: pulse frame_err, zero the counters, stay in FILL, and discard the partial frame.
REQ-024 SHALL treat in_last=0 on pixel index N-1 as a missing terminator: pulse frame_err, zero the counters, stay in FILL, and discard the frame.
REQ-025 SHALL NOT clear frame contents on discard; stale words are overwritten by the next frame.
REQ-026 SHALL ignore frame_ready while in FILL.

Reset
REQ-027 SHALL, on rst=1, asynchronously force state FILL, all counters 0, frame all zeros, frame_valid=0, frame_err=0 and in_ready=1 once rst deasserts.
REQ-028 SHALL, on rst mid-frame or in FULL, drop the frame in progress; the first accepted pixel after reset is index 0.

Configuration
REQ-029 SHALL, when macro FRAME_ASSEMBLER_RELU_EN is defined, store max(in_data,0) (negative samples stored as 0).
REQ-030 SHALL, without FRAME_ASSEMBLER_RELU_EN, store in_data unmodified.

Structure
REQ-031 SHALL take the state encoding (FILL, FULL) and the frame-size function N from the shared package cnn_pkg.
REQ-032 SHALL implement the column/row/channel wrap logic as one sub-module, frame_counter.

Verification
REQ-033 SHALL show, with rows=3, cols=3, in_channels=1, that 9 pixels 1..9 with in_last on the 9th give frame_valid=1 one cycle later and frame[7:0]=1, frame[71:64]=9.
REQ-034 SHALL show that frame_ready held at 0 for 5 cycles keeps frame stable and in_ready=0, and that frame_ready=1 clears frame_valid the next cycle.
REQ-035 SHALL show that in_last on the 4th pixel gives frame_err=1 for exactly one cycle, and that the next 9 pixels then form a correct frame.
REQ-036 SHALL show, with in_channels=2, that pixel index 9 lands at frame[79:72] (c=1, r=0, x=0).
REQ-037 SHALL show, with FRAME_ASSEMBLER_RELU_EN defined, that input -5 is stored as 0; without the macro it is stored as 8'hFB.
REQ-038 SHALL show that rst pulsed after 5 pixels, then 9 fresh pixels, gives a frame holding only the fresh values.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN definitions: frame assembler FSM state encoding and frame-size helpers.
package cnn_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } asm_state_e;

  // Number of pixels in one frame (N).
  function automatic int frame_size(input int ch, input int r, input int c);
    return ch * r * c;
  endfunction

  // Counter width for a modulus of n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_counter.sv
// Column/row/channel position counter for the frame assembler; column runs fastest.
module frame_counter
  import cnn_pkg::*;
#(
  parameter int in_channels = 1,
  parameter int rows        = 27,
  parameter int cols        = 27
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear_i,
  input  logic                          advance_i,
  output logic [cnt_w(cols)-1:0]        col_o,
  output logic [cnt_w(rows)-1:0]        row_o,
  output logic [cnt_w(in_channels)-1:0] chan_o,
  output logic                          last_o
);

  localparam int CW = cnt_w(cols);
  localparam int RW = cnt_w(rows);
  localparam int HW = cnt_w(in_channels);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [HW-1:0] chan_q, chan_d;
  logic          col_end, row_end, chan_end;

  assign col_end  = (col_q == CW'(cols - 1));
  assign row_end  = (row_q == RW'(rows - 1));
  assign chan_end = (chan_q == HW'(in_channels - 1));

  // Clear wins over advance so a terminating pixel leaves the counters at zero.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    chan_d = chan_q;
    if (clear_i) begin
      col_d  = '0;
      row_d  = '0;
      chan_d = '0;
    end else if (advance_i) begin
      if (col_end) begin
        col_d = '0;
        if (row_end) begin
          row_d  = '0;
          chan_d = chan_end ? '0 : chan_q + 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      chan_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      chan_q <= chan_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign chan_o = chan_q;
  assign last_o = col_end && row_end && chan_end;

endmodule

// File: rtl/frame_assembler.sv
// Collects a channel-major pixel stream into one packed frame for the pooling stage.
// Optional: define FRAME_ASSEMBLER_RELU_EN to store max(in_data,0) instead of raw samples.
module frame_assembler
  import cnn_pkg::*;
#(
  parameter int in_channels = 1,
  parameter int rows        = 27,
  parameter int cols        = 27,
  parameter int data_size   = 8
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic signed [data_size-1:0]                 in_data,
  input  logic                                        in_valid,
  input  logic                                        in_last,
  output logic                                        in_ready,
  output logic [in_channels*rows*cols*data_size-1:0]  frame,
  output logic                                        frame_valid,
  input  logic                                        frame_ready,
  output logic                                        frame_err,
  output asm_state_e                                  state_dbg
);

  // Handshake: a pixel moves when in_valid && in_ready on a rising edge; a frame
  // is consumed when frame_valid && frame_ready on a rising edge.

  localparam int N  = frame_size(in_channels, rows, cols);
  localparam int FW = N * data_size;
  localparam int BW = cnt_w(FW);

  asm_state_e                 state_q;
  logic [FW-1:0]              frame_q;
  logic                       frame_valid_q;
  logic                       frame_err_q;
  logic [cnt_w(cols)-1:0]     col;
  logic [cnt_w(rows)-1:0]     row;
  logic [cnt_w(in_channels)-1:0] chan;
  logic                       at_last;
  logic                       accept;
  logic [data_size-1:0]       pixel;
  logic [BW-1:0]              base;

  assign accept = in_valid && (state_q == FILL);

  always_comb begin
`ifdef FRAME_ASSEMBLER_RELU_EN
    pixel = in_data[data_size-1] ? '0 : in_data;
`else
    pixel = in_data;
`endif
  end

  always_comb begin
    base = BW'((int'(chan) * rows * cols + int'(row) * cols + int'(col)) * data_size);
  end

  frame_counter #(
    .in_channels(in_channels),
    .rows       (rows),
    .cols       (cols)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (accept && (in_last || at_last)),
    .advance_i(accept),
    .col_o    (col),
    .row_o    (row),
    .chan_o   (chan),
    .last_o   (at_last)
  );

  // Partial or unterminated frames are not cleared; the next frame overwrites them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FILL;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        FILL: begin
          if (accept) begin
            frame_q[base +: data_size] <= pixel;
            if (at_last && in_last) begin
              state_q       <= FULL;
              frame_valid_q <= 1'b1;
            end else if (at_last || in_last) begin
              frame_err_q <= 1'b1;
            end
          end
        end
        FULL: begin
          if (frame_ready) begin
            state_q       <= FILL;
            frame_valid_q <= 1'b0;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign in_ready    = (state_q == FILL);
  assign frame       = frame_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign state_dbg   = state_q;

endmodule
